// File: rtl/video_timing_monitor.sv
// Video timing monitor: measures pixels per line and lines per frame from the
// core's sync outputs, reports lock and 50/60 Hz classification. Observe-only.
module video_timing_monitor #(
  parameter int unsigned LOCK_FRAMES    = 4,
  parameter int unsigned LINES_60HZ_MAX = 287
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk14en,
  input  logic        hsync_n,
  input  logic        vsync_n,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        locked,
  output logic        is_60hz,
  output logic        frame_strobe
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [3:0]  MATCH_LAST = 4'(LOCK_FRAMES - 2);
  localparam logic [9:0]  LINES_60   = 10'(LINES_60HZ_MAX);
  localparam logic [10:0] PIX_MAX    = '1;
  localparam logic [9:0]  LINE_MAX   = '1;

  state_t      state, next_state;
  logic        hs_q, vs_q;
  logic [10:0] pix_cnt;
  logic [9:0]  line_cnt;
  logic        hs_seen;
  logic [10:0] cur_len;
  logic        line_var;
  logic [10:0] ref_len;
  logic [9:0]  ref_lines;
  logic        ref_valid;
  logic [3:0]  match_cnt;

  logic        hs_fall, vs_fall, meas_valid, frame_var;
  logic        timeout, frame_end, mismatch;
  logic [10:0] frame_len;
  logic [9:0]  frame_total, lines_next;

  // Edge decode and frame-end summary; a line ending on the frame-end tick is
  // folded into the frame being closed.
  always_comb begin
    hs_fall     = clk14en & hs_q & ~hsync_n;
    vs_fall     = clk14en & vs_q & ~vsync_n;
    meas_valid  = hs_fall & hs_seen;
    frame_len   = (meas_valid && cur_len == '0) ? pix_cnt : cur_len;
    frame_var   = line_var | (meas_valid & (cur_len != '0) & (pix_cnt != cur_len));
    frame_total = (hs_fall && line_cnt != LINE_MAX) ? line_cnt + 10'd1 : line_cnt;
    timeout     = clk14en & ((~hs_fall & (pix_cnt >= PIX_MAX - 11'd1)) |
                             (frame_total == LINE_MAX));
    frame_end   = vs_fall & (state != SEARCH) & ~timeout;
    mismatch    = ~ref_valid | frame_var | (frame_len != ref_len) |
                  (frame_total != ref_lines);
    lines_next  = frame_end ? frame_total : frame_lines;
  end

  // Next-state logic; a timeout overrides everything.
  always_comb begin
    next_state = state;
    if (timeout) begin
      next_state = SEARCH;
    end else begin
      case (state)
        SEARCH:  if (vs_fall) next_state = MEASURE;
        MEASURE: if (frame_end && !mismatch && match_cnt == MATCH_LAST) next_state = LOCKED;
        LOCKED:  if (frame_end && mismatch) next_state = MEASURE;
        default: next_state = SEARCH;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= SEARCH;
    else        state <= next_state;
  end

  // Sync sampling, pixel/line counters and per-frame measurement bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      pix_cnt   <= 11'd1;
      line_cnt  <= '0;
      hs_seen   <= 1'b0;
      cur_len   <= '0;
      line_var  <= 1'b0;
      ref_len   <= '0;
      ref_lines <= '0;
      ref_valid <= 1'b0;
      match_cnt <= '0;
    end else begin
      if (clk14en) begin
        hs_q <= hsync_n;
        vs_q <= vsync_n;
      end
      if (hs_fall)                         pix_cnt <= 11'd1;
      else if (clk14en && pix_cnt != PIX_MAX) pix_cnt <= pix_cnt + 11'd1;
      if (vs_fall)      line_cnt <= '0;
      else if (hs_fall) line_cnt <= frame_total;

      if (timeout || state == SEARCH) begin
        hs_seen   <= 1'b0;
        cur_len   <= '0;
        line_var  <= 1'b0;
        ref_valid <= 1'b0;
        match_cnt <= '0;
      end else begin
        if (hs_fall) hs_seen <= 1'b1;
        if (frame_end) begin
          cur_len  <= '0;
          line_var <= 1'b0;
          if (mismatch) begin
            ref_len   <= frame_len;
            ref_lines <= frame_total;
            ref_valid <= ~frame_var;
            match_cnt <= '0;
          end else if (state == MEASURE) begin
            match_cnt <= match_cnt + 4'd1;
          end
        end else if (meas_valid) begin
          if (cur_len == '0)         cur_len  <= pix_cnt;
          else if (pix_cnt != cur_len) line_var <= 1'b1;
        end
      end
    end
  end

  // Reported measurements and status, registered from next-state values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_len     <= '0;
      frame_lines  <= '0;
      locked       <= 1'b0;
      is_60hz      <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      frame_strobe <= frame_end;
      locked       <= (next_state == LOCKED);
      is_60hz      <= (next_state == LOCKED) && (lines_next <= LINES_60);
      if (timeout) begin
        line_len    <= '0;
        frame_lines <= '0;
      end else if (frame_end) begin
        line_len    <= frame_len;
        frame_lines <= frame_total;
      end
    end
  end

endmodule
